// File: rtl/mbc_pkg.sv
// Constants shared by the basic-computer control unit: sequence counter width and
// terminal count, used by both the sequencer and the timing decoder.
package mbc_pkg;

  localparam int unsigned SC_WIDTH = 4;
  localparam int unsigned SC_MAX   = (2 ** SC_WIDTH) - 1;

endpackage : mbc_pkg

// File: rtl/step_edge_detect.sv
// Registered rising-edge detector for the debug STEP button.
module step_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic step,
  output logic step_rise
);

  logic step_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  // Combinational so a press is acted on at the same edge that first samples it.
  assign step_rise = step & ~step_q;

endmodule : step_edge_detect

// File: rtl/sc_sequencer.sv
// Sequence counter for the control unit: a timing counter gated by the S (run)
// flip-flop, with halt, end-of-instruction clear and single-step debug.
module sc_sequencer
  import mbc_pkg::*;
#(
  parameter int unsigned WIDTH = SC_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             HALT,
  input  logic             SC_CLR,
  input  logic             STEP_MODE,
  input  logic             STEP,
  output logic [WIDTH-1:0] SC_OUT,
  output logic             RUN,
  output logic             WRAP_ERR
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic step_rise;
  logic adv;
  logic fresh_start;
  logic wrapping;

  step_edge_detect u_step_edge (
    .clk       (CLK),
    .rst       (RST),
    .step      (STEP),
    .step_rise (step_rise)
  );

  assign adv         = RUN & (~STEP_MODE | step_rise);
  assign fresh_start = START & ~RUN & ~HALT;
  assign wrapping    = adv & ~SC_CLR & ~HALT & (SC_OUT == ALL_ONES);

  always_ff @(posedge CLK) begin
    if (RST) begin
      SC_OUT   <= '0;
      RUN      <= 1'b0;
      WRAP_ERR <= 1'b0;
    end else begin
      // Counter: halt and end-of-instruction clear both beat an advance.
      if (HALT || SC_CLR) begin
        SC_OUT <= '0;
      end else if (adv) begin
        SC_OUT <= SC_OUT + WIDTH'(1);
      end

      if (HALT) begin
        RUN <= 1'b0;
      end else if (START && !RUN) begin
        RUN <= 1'b1;
      end

      // Sticky until a fresh run begins; start and advance are mutually exclusive.
      if (fresh_start) begin
        WRAP_ERR <= 1'b0;
      end else if (wrapping) begin
        WRAP_ERR <= 1'b1;
      end
    end
  end

endmodule : sc_sequencer

// File: tb/tb_sc_sequencer.sv
// Directed bench for sc_sequencer: stimulus pushes hand-computed expected state,
// a separate monitor pops and compares after every rising edge.
module tb_sc_sequencer;

  localparam logic [5:0] I_NONE  = 6'b000000;
  localparam logic [5:0] I_RST   = 6'b100000;
  localparam logic [5:0] I_START = 6'b010000;
  localparam logic [5:0] I_HALT  = 6'b001000;
  localparam logic [5:0] I_CLR   = 6'b000100;
  localparam logic [5:0] I_SMODE = 6'b000010;
  localparam logic [5:0] I_STEP  = 6'b000001;

  typedef struct packed {
    logic [3:0] sc;
    logic       run;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       sc_clr = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic [3:0] sc_out;
  logic       run;
  logic       wrap_err;

  exp_t exp_q[$];
  int   n_compared = 0;
  int   n_failed   = 0;

  sc_sequencer #(.WIDTH(4)) dut (
    .CLK       (clk),
    .RST       (rst),
    .START     (start),
    .HALT      (halt),
    .SC_CLR    (sc_clr),
    .STEP_MODE (step_mode),
    .STEP      (step),
    .SC_OUT    (sc_out),
    .RUN       (run),
    .WRAP_ERR  (wrap_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and record the state expected after the next edge.
  task automatic cyc(input logic [5:0] in, input logic [3:0] esc,
                     input logic erun, input logic ewrap);
    exp_t e;
    @(negedge clk);
    {rst, start, halt, sc_clr, step_mode, step} = in;
    e.sc   = esc;
    e.run  = erun;
    e.wrap = ewrap;
    exp_q.push_back(e);
  endtask

  // Monitor: the DUT presents a new state every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_compared++;
        if (sc_out !== e.sc || run !== e.run || wrap_err !== e.wrap) begin
          n_failed++;
          $display("FAIL state #%0d: got sc=%0d run=%b wrap=%b, expected sc=%0d run=%b wrap=%b",
                   n_compared, sc_out, run, wrap_err, e.sc, e.run, e.wrap);
        end
      end
    end
  end

  initial begin
    // Reset, then start: T0 shown for one cycle, then 1,2,3.
    cyc(I_RST, 4'd0, 1'b0, 1'b0);
    cyc(I_RST, 4'd0, 1'b0, 1'b0);
    cyc(I_START, 4'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) cyc(I_NONE, 4'(i), 1'b1, 1'b0);

    // End-of-instruction clear at SC=3.
    cyc(I_CLR, 4'd0, 1'b1, 1'b0);
    cyc(I_NONE, 4'd1, 1'b1, 1'b0);
    cyc(I_NONE, 4'd2, 1'b1, 1'b0);

    // Wrap past 15 without a clear; error is sticky.
    for (int i = 3; i <= 15; i++) cyc(I_NONE, 4'(i), 1'b1, 1'b0);
    cyc(I_NONE, 4'd0, 1'b1, 1'b1);
    cyc(I_NONE, 4'd1, 1'b1, 1'b1);
    cyc(I_NONE, 4'd2, 1'b1, 1'b1);
    cyc(I_HALT, 4'd0, 1'b0, 1'b1);
    cyc(I_START, 4'd0, 1'b1, 1'b0);

    // HALT beats START at SC=5; counter then frozen at 0.
    for (int i = 1; i <= 5; i++) cyc(I_NONE, 4'(i), 1'b1, 1'b0);
    cyc(I_HALT | I_START, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(I_NONE, 4'd0, 1'b0, 1'b0);

    // Single step: STEP high 6, low 2, high 1.
    cyc(I_SMODE | I_START, 4'd0, 1'b1, 1'b0);
    cyc(I_SMODE | I_STEP, 4'd1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(I_SMODE | I_STEP, 4'd1, 1'b1, 1'b0);
    cyc(I_SMODE, 4'd1, 1'b1, 1'b0);
    cyc(I_SMODE, 4'd1, 1'b1, 1'b0);
    cyc(I_SMODE | I_STEP, 4'd2, 1'b1, 1'b0);
    cyc(I_SMODE, 4'd2, 1'b1, 1'b0);

    // Back to free run, wrap to set the error, then reset at SC=9.
    for (int i = 3; i <= 15; i++) cyc(I_NONE, 4'(i), 1'b1, 1'b0);
    cyc(I_NONE, 4'd0, 1'b1, 1'b1);
    for (int i = 1; i <= 9; i++) cyc(I_NONE, 4'(i), 1'b1, 1'b1);
    cyc(I_RST | I_START, 4'd0, 1'b0, 1'b0);

    // A STEP press while stopped is discarded; a later press advances.
    cyc(I_SMODE | I_STEP, 4'd0, 1'b0, 1'b0);
    cyc(I_SMODE | I_START, 4'd0, 1'b1, 1'b0);
    cyc(I_SMODE | I_STEP, 4'd1, 1'b1, 1'b0);

    // Clear coinciding with an advance from 15: clear wins, no error.
    for (int i = 2; i <= 15; i++) cyc(I_NONE, 4'(i), 1'b1, 1'b0);
    cyc(I_CLR, 4'd0, 1'b1, 1'b0);
    cyc(I_NONE, 4'd1, 1'b1, 1'b0);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_failed++;
      $display("FAIL drain: %0d expected states left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule : tb_sc_sequencer
